frame_rr_arbiter: RTL

Round-robin frame arbiter that shares one output stream between N_CH channel FIFOs carrying framed 64-bit data. A frame starts with a header word, where bits[63:48]=16'hAAAA, and ends with a footer word, where bits[15:0]=16'h5555 and bits[63:62]=2'b11. The block grants one channel at a time and moves exactly one frame per grant. It repairs framing faults by inserting error header or footer words. It sits between the per-channel FIFOs and the downstream packer/DMA, replacing fixed-priority mixing.

---
 rtl/frame_pkg.sv | 29 ++
 rtl/rr_pick.sv | 52 +++++
 rtl/frame_rr_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared framing definitions for the frame round-robin arbiter.
// Holds the frame marker IDs, the header/footer classifiers and the arbiter
// FSM state encoding.
package frame_pkg;

    localparam int          ID_WIDTH        = 16;
    localparam logic [15:0] HEADER_ID       = 16'hAAAA;
    localparam logic [15:0] FOOTER_ID       = 16'h5555;
    localparam logic [15:0] ERROR_HEADER_ID = 16'hAAEE;
    localparam logic [15:0] ERROR_FOOTER_ID = 16'h55EE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STREAM  = 2'd1,
        ST_INS_HDR = 2'd2,
        ST_INS_FTR = 2'd3
    } state_t;

    // top16 = word[MSB -: 16]
    function automatic logic is_header(input logic [15:0] top16);
        return top16 == HEADER_ID;
    endfunction

    // top2 = word[MSB -: 2], low16 = word[15:0]
    function automatic logic is_footer(input logic [1:0] top2, input logic [15:0] low16);
        return (top2 == 2'b11) && (low16 == FOOTER_ID);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req   - request vector, one bit per channel
//   last  - previously granted channel; search starts at last+1 (mod N_CH)
//   grant - first requesting channel found
//   found - at least one request present
module rr_pick #(
    parameter int N_CH = 4,
    parameter int GW   = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [GW-1:0]   last,
    output logic [GW-1:0]   grant,
    output logic            found
);

    localparam int SW = GW + 2;

    logic [2*N_CH-1:0] req_dbl;
    logic [SW-1:0]     shamt;
    logic [N_CH-1:0]   rot;
    logic [N_CH-1:0]   hit;

    // Rotating a doubled vector puts channel (last+1) mod N_CH at bit 0.
    assign req_dbl = {req, req};
    assign shamt   = SW'(last) + SW'(1);
    assign rot     = N_CH'(req_dbl >> shamt);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_pick
            logic [SW-1:0] sum;
            logic [GW-1:0] cand;
            logic [GW-1:0] acc;

            assign sum  = SW'(last) + SW'(gi + 1);
            assign cand = (sum >= SW'(N_CH)) ? GW'(sum - SW'(N_CH)) : GW'(sum);

            if (gi == 0) begin : g_first
                assign hit[gi] = rot[0];
                assign acc     = hit[gi] ? cand : '0;
            end else begin : g_rest
                assign hit[gi] = rot[gi] & ~(|rot[gi-1:0]);
                assign acc     = g_pick[gi-1].acc | (hit[gi] ? cand : '0);
            end
        end
    endgenerate

    assign grant = g_pick[N_CH-1].acc;
    assign found = |req;

endmodule

// File: rtl/frame_rr_arbiter.sv
// Round-robin frame arbiter: shares one registered output stream between
// N_CH FWFT channel FIFOs, moving exactly one frame per grant and repairing
// missing headers/footers with error marker words.
// Ports:
//   CLK, RESETN      - clock, synchronous active-low reset
//   CH_DIN           - head word of each FIFO, ch k at [k*DATA_WIDTH +: DATA_WIDTH]
//   CH_VALID         - FIFO not empty
//   CH_READ_REQUEST  - FIFO holds at least one complete frame
//   CH_RE            - pop strobe (combinational)
//   DOUT, oVALID     - output word register and its valid
//   iREADY           - downstream accept
//   GRANT_ID         - channel currently or last granted
//   BUSY             - FSM not idle
//   ERR_PULSE        - [0] header lost, [1] footer lost, [2] timeout/overlength
module frame_rr_arbiter
    import frame_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int N_CH            = 4,
    parameter int TIMEOUT         = 1024,
    parameter int MAX_FRAME_WORDS = 256
) (
    input  logic                         CLK,
    input  logic                         RESETN,
    input  logic [N_CH*DATA_WIDTH-1:0]   CH_DIN,
    input  logic [N_CH-1:0]              CH_VALID,
    input  logic [N_CH-1:0]              CH_READ_REQUEST,
    output logic [N_CH-1:0]              CH_RE,
    output logic [DATA_WIDTH-1:0]        DOUT,
    output logic                         oVALID,
    input  logic                         iREADY,
    output logic [$clog2(N_CH)-1:0]      GRANT_ID,
    output logic                         BUSY,
    output logic [2:0]                   ERR_PULSE
);

    localparam int GW  = $clog2(N_CH);
    localparam int WCW = $clog2(MAX_FRAME_WORDS + 1);
    localparam int SCW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] STREAM  = ST_STREAM;
    localparam logic [1:0] INS_HDR = ST_INS_HDR;
    localparam logic [1:0] INS_FTR = ST_INS_FTR;

    localparam logic [DATA_WIDTH-1:0] ERR_HDR_WORD = {ERROR_HEADER_ID, {(DATA_WIDTH-ID_WIDTH){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] ERR_FTR_WORD = {{(DATA_WIDTH-ID_WIDTH){1'b1}}, ERROR_FOOTER_ID};
    localparam logic [DATA_WIDTH-1:0] RESET_WORD   = {{ID_WIDTH{1'b0}}, {(DATA_WIDTH-ID_WIDTH){1'b1}}};
    localparam logic [WCW-1:0]        LAST_CNT     = WCW'(MAX_FRAME_WORDS - 1);
    localparam logic [SCW-1:0]        STALL_LIM    = SCW'(TIMEOUT - 1);

    logic [1:0]            state_reg, state_next;
    logic [GW-1:0]         grant_reg, grant_next;
    logic [WCW-1:0]        word_cnt_reg, word_cnt_next;
    logic [SCW-1:0]        stall_cnt_reg, stall_cnt_next;
    logic [DATA_WIDTH-1:0] dout_reg;
    logic                  ovalid_reg;
    logic [2:0]            err_reg, err_next;

    logic                  ld;
    logic                  load_en;
    logic [DATA_WIDTH-1:0] load_word;
    logic                  pop;
    logic [GW-1:0]         pick_grant;
    logic                  pick_found;

    logic [DATA_WIDTH-1:0] ch_word [N_CH];
    logic [DATA_WIDTH-1:0] head;
    logic                  head_valid;
    logic                  head_ftr;
    logic                  head_hdr;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign ch_word[gi] = CH_DIN[gi*DATA_WIDTH +: DATA_WIDTH];
            assign CH_RE[gi]   = pop && (grant_reg == GW'(gi));
        end
    endgenerate

    rr_pick #(
        .N_CH (N_CH),
        .GW   (GW)
    ) u_pick (
        .req   (CH_READ_REQUEST),
        .last  (grant_reg),
        .grant (pick_grant),
        .found (pick_found)
    );

    assign ld         = !ovalid_reg || iREADY;
    assign head       = ch_word[grant_reg];
    assign head_valid = CH_VALID[grant_reg];
    // A word matching both patterns is treated as a footer.
    assign head_ftr   = is_footer(head[DATA_WIDTH-1 -: 2], head[15:0]);
    assign head_hdr   = is_header(head[DATA_WIDTH-1 -: ID_WIDTH]) && !head_ftr;

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        word_cnt_next  = word_cnt_reg;
        stall_cnt_next = stall_cnt_reg;
        err_next       = 3'b000;
        load_en        = 1'b0;
        load_word      = head;
        pop            = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_next     = pick_grant;
                    state_next     = STREAM;
                    word_cnt_next  = '0;
                    stall_cnt_next = '0;
                end
            end
            STREAM: begin
                if (ld && head_valid) begin
                    if (word_cnt_reg == '0 && !head_hdr) begin
                        // Missing header: leave the word in the FIFO and
                        // send it as payload after the inserted header.
                        state_next = INS_HDR;
                        err_next   = 3'b001;
                    end else if (word_cnt_reg != '0 && head_hdr) begin
                        // Next frame's header arrived: close this one and
                        // leave the header for the channel's next grant.
                        state_next = INS_FTR;
                        err_next   = 3'b010;
                    end else begin
                        pop            = 1'b1;
                        load_en        = 1'b1;
                        stall_cnt_next = '0;
                        word_cnt_next  = word_cnt_reg + WCW'(1);
                        if (head_ftr) begin
                            state_next = IDLE;
                        end else if (word_cnt_reg == LAST_CNT) begin
                            state_next = INS_FTR;
                            err_next   = 3'b100;
                        end
                    end
                end else begin
                    stall_cnt_next = stall_cnt_reg + SCW'(1);
                    if (stall_cnt_reg == STALL_LIM) begin
                        state_next = INS_FTR;
                        err_next   = 3'b100;
                    end
                end
            end
            INS_HDR: begin
                if (ld) begin
                    load_en        = 1'b1;
                    load_word      = ERR_HDR_WORD;
                    state_next     = STREAM;
                    word_cnt_next  = WCW'(1);
                    stall_cnt_next = '0;
                end
            end
            default: begin
                if (ld) begin
                    load_en    = 1'b1;
                    load_word  = ERR_FTR_WORD;
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_reg     <= IDLE;
            grant_reg     <= GW'(N_CH - 1);
            word_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
            dout_reg      <= RESET_WORD;
            ovalid_reg    <= 1'b0;
            err_reg       <= 3'b000;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            word_cnt_reg  <= word_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
            err_reg       <= err_next;
            if (load_en) begin
                dout_reg   <= load_word;
                ovalid_reg <= 1'b1;
            end else if (ld) begin
                ovalid_reg <= 1'b0;
            end
        end
    end

    assign DOUT      = dout_reg;
    assign oVALID    = ovalid_reg;
    assign GRANT_ID  = grant_reg;
    assign BUSY      = (state_reg != IDLE);
    assign ERR_PULSE = err_reg;

endmodule
